band_rate_readout: RTL and testbench

- Readout end of the per-antenna band trigger path: consumes the latched 24-bit band rate words, the rate tick and the 24-bit band hit-pattern history from N_ANT band channels.
- Snapshots each rate or hit-pattern event into a shadow buffer.
- Streams each snapshot as a framed byte stream with a valid/ready handshake toward the DAQ link.
- Sits between the band channel array and the station readout serializer.

---
 rtl/band_readout_pkg.sv | 30 +++
 rtl/band_shadow_buf.sv | 42 ++++
 rtl/band_rate_readout.sv | 217 +++++++++++++++++++++
 tb/tb_band_rate_readout.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/band_readout_pkg.sv
// Shared types and constants for the band readout path.
// BAND_READOUT_TIMESTAMP_EN adds a 3-byte count_1M timestamp to hit frames.
package band_readout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEQ,
        ST_TS,
        ST_DATA,
        ST_CSUM
    } state_t;

    localparam logic [7:0]  HDR_RATE_DEF   = 8'hA5;
    localparam logic [7:0]  HDR_HIT_DEF    = 8'h5A;
    localparam int unsigned BYTES_PER_WORD = 3;
    localparam int unsigned WORD_W         = 24;

`ifdef BAND_READOUT_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Bytes in one frame: header, sequence, optional timestamp, data, checksum.
    function automatic int unsigned frame_len(input int unsigned n_ant, input bit is_hit);
        return BYTES_PER_WORD * n_ant + 3 + ((TS_EN && is_hit) ? BYTES_PER_WORD : 0);
    endfunction

endpackage

// File: rtl/band_shadow_buf.sv
// One-deep snapshot buffer: rising-edge event capture, full flag and
// saturating drop counter for events that arrive while the buffer is full.
module band_shadow_buf #(
    parameter int unsigned W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         trig,
    input  logic [W-1:0] din,
    input  logic         clr,
    output logic [W-1:0] data,
    output logic         full,
    output logic [7:0]   drops
);

    logic trig_d;
    logic ev_c;

    assign ev_c = trig && !trig_d;

    // A clear in the same cycle as an event still sees full set, so the event drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_d <= 1'b0;
            data   <= '0;
            full   <= 1'b0;
            drops  <= '0;
        end else begin
            trig_d <= trig;
            if (ev_c) begin
                if (full) begin
                    if (drops != 8'hFF) drops <= drops + 8'd1;
                end else begin
                    data <= din;
                    full <= 1'b1;
                end
            end
            if (clr) full <= 1'b0;
        end
    end

endmodule

// File: rtl/band_rate_readout.sv
// Snapshots band rate / hit-pattern words and streams them as checksummed byte frames.
// Define BAND_READOUT_TIMESTAMP_EN to carry count_1M in hit frames.
module band_rate_readout
    import band_readout_pkg::*;
#(
    parameter int unsigned N_ANT    = 8,
    parameter logic [7:0]  HDR_RATE = HDR_RATE_DEF,
    parameter logic [7:0]  HDR_HIT  = HDR_HIT_DEF
) (
    input  logic                  clk_r2,
    input  logic                  reset_n,
    input  logic [24*N_ANT-1:0]   rate_bus,
    input  logic                  tick,
    input  logic [24*N_ANT-1:0]   bp_bus,
    input  logic [3:0]            trigger_shifter,
    input  logic [23:0]           count_1M,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            drop_rate,
    output logic [7:0]            drop_hit,
    output logic                  busy
);

    localparam int unsigned DW  = WORD_W * N_ANT;
    localparam int unsigned HW  = DW + (TS_EN ? WORD_W : 0);
    localparam int unsigned NDB = BYTES_PER_WORD * N_ANT;
    localparam int unsigned WIW = (N_ANT > 1) ? $clog2(N_ANT) : 1;
    localparam int unsigned DCW = $clog2(NDB + 1);

    state_t          state;
    logic            sel_hit;
    logic [7:0]      csum;
    logic [7:0]      seq_rate;
    logic [7:0]      seq_hit;
    logic [WIW-1:0]  wi;
    logic [1:0]      bi;
    logic [DCW-1:0]  dcnt;
    logic [1:0]      tcnt;

    logic [DW-1:0]   rate_data;
    logic [HW-1:0]   hit_data;
    logic [HW-1:0]   hit_din;
    logic            rate_full;
    logic            hit_full;
    logic            hs_c;
    logic            clr_rate_c;
    logic            clr_hit_c;
    logic            hit_phase_c;
    logic [23:0]     ts_word_c;
    logic [DW-1:0]   payload_c;
    logic [23:0]     word_c;
    logic [7:0]      data_byte_c;
    logic [7:0]      ts_byte_c;
    logic [7:0]      hdr_c;
    logic [7:0]      seq_c;
    logic [WIW-1:0]  wi_nx_c;
    logic [1:0]      bi_nx_c;

    assign hs_c        = out_valid && out_ready;
    assign clr_rate_c  = (state == ST_CSUM) && hs_c && !sel_hit;
    assign clr_hit_c   = (state == ST_CSUM) && hs_c && sel_hit;
    assign hit_phase_c = (trigger_shifter == 4'h4);

`ifdef BAND_READOUT_TIMESTAMP_EN
    assign hit_din   = {count_1M, bp_bus};
    assign ts_word_c = hit_data[HW-1 -: 24];
`else
    logic unused_ts;
    assign unused_ts = ^count_1M;
    assign hit_din   = bp_bus;
    assign ts_word_c = '0;
`endif

    band_shadow_buf #(.W(DW)) u_rate (
        .clk   (clk_r2),
        .rst_n (reset_n),
        .trig  (tick),
        .din   (rate_bus),
        .clr   (clr_rate_c),
        .data  (rate_data),
        .full  (rate_full),
        .drops (drop_rate)
    );

    band_shadow_buf #(.W(HW)) u_hit (
        .clk   (clk_r2),
        .rst_n (reset_n),
        .trig  (hit_phase_c),
        .din   (hit_din),
        .clr   (clr_hit_c),
        .data  (hit_data),
        .full  (hit_full),
        .drops (drop_hit)
    );

    // Byte muxes: wi/bi and tcnt point at the next byte to be loaded.
    always_comb begin
        payload_c = sel_hit ? hit_data[DW-1:0] : rate_data;
        word_c    = payload_c[WORD_W*wi +: WORD_W];
        hdr_c     = sel_hit ? HDR_HIT : HDR_RATE;
        seq_c     = sel_hit ? seq_hit : seq_rate;
        case (bi)
            2'd0:    data_byte_c = word_c[23:16];
            2'd1:    data_byte_c = word_c[15:8];
            default: data_byte_c = word_c[7:0];
        endcase
        case (tcnt)
            2'd0:    ts_byte_c = ts_word_c[23:16];
            2'd1:    ts_byte_c = ts_word_c[15:8];
            default: ts_byte_c = ts_word_c[7:0];
        endcase
        bi_nx_c = (bi == 2'd2) ? 2'd0 : bi + 2'd1;
        wi_nx_c = (bi == 2'd2 && wi != WIW'(N_ANT - 1)) ? wi + WIW'(1) : wi;
    end

    // HDR spends one cycle priming the output register, giving a 2-cycle start latency.
    always_ff @(posedge clk_r2 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            sel_hit   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            csum      <= '0;
            seq_rate  <= '0;
            seq_hit   <= '0;
            wi        <= '0;
            bi        <= '0;
            dcnt      <= '0;
            tcnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rate_full || hit_full) begin
                        sel_hit <= hit_full;
                        busy    <= 1'b1;
                        state   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= hdr_c;
                        csum      <= hdr_c;
                    end else if (hs_c) begin
                        out_data <= seq_c;
                        csum     <= csum ^ seq_c;
                        wi       <= '0;
                        bi       <= '0;
                        dcnt     <= '0;
                        tcnt     <= '0;
                        state    <= ST_SEQ;
                    end
                end
                ST_SEQ: begin
                    if (hs_c) begin
                        if (TS_EN && sel_hit) begin
                            out_data <= ts_byte_c;
                            csum     <= csum ^ ts_byte_c;
                            tcnt     <= 2'd1;
                            state    <= ST_TS;
                        end else begin
                            out_data <= data_byte_c;
                            csum     <= csum ^ data_byte_c;
                            wi       <= wi_nx_c;
                            bi       <= bi_nx_c;
                            dcnt     <= dcnt + DCW'(1);
                            state    <= ST_DATA;
                        end
                    end
                end
                ST_TS: begin
                    if (hs_c) begin
                        if (tcnt == 2'd3) begin
                            out_data <= data_byte_c;
                            csum     <= csum ^ data_byte_c;
                            wi       <= wi_nx_c;
                            bi       <= bi_nx_c;
                            dcnt     <= dcnt + DCW'(1);
                            state    <= ST_DATA;
                        end else begin
                            out_data <= ts_byte_c;
                            csum     <= csum ^ ts_byte_c;
                            tcnt     <= tcnt + 2'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (hs_c) begin
                        if (dcnt == DCW'(NDB)) begin
                            out_data <= csum;
                            state    <= ST_CSUM;
                        end else begin
                            out_data <= data_byte_c;
                            csum     <= csum ^ data_byte_c;
                            wi       <= wi_nx_c;
                            bi       <= bi_nx_c;
                            dcnt     <= dcnt + DCW'(1);
                        end
                    end
                end
                ST_CSUM: begin
                    if (hs_c) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                        if (sel_hit) seq_hit  <= seq_hit + 8'd1;
                        else         seq_rate <= seq_rate + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_band_rate_readout.sv
// Scoreboard bench for band_rate_readout with N_ANT=2: directed frames pushed
// as expected bytes, a negedge monitor pops and compares every accepted byte.
module tb_band_rate_readout;

    logic        clk;
    logic        reset_n;
    logic [47:0] rate_bus;
    logic        tick;
    logic [47:0] bp_bus;
    logic [3:0]  trigger_shifter;
    logic [23:0] count_1M;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  drop_rate;
    logic [7:0]  drop_hit;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    int          hs_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_b;
    logic        held_v = 1'b0;
    logic [7:0]  held_d = 8'h00;

    band_rate_readout #(.N_ANT(2)) dut (
        .clk_r2          (clk),
        .reset_n         (reset_n),
        .rate_bus        (rate_bus),
        .tick            (tick),
        .bp_bus          (bp_bus),
        .trigger_shifter (trigger_shifter),
        .count_1M        (count_1M),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .drop_rate       (drop_rate),
        .drop_hit        (drop_hit),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_frame(input bit hit, input logic [7:0] seq, input logic [47:0] d);
        logic [7:0]  hdr;
        logic [7:0]  cs;
        logic [23:0] w;
        hdr = hit ? 8'h5A : 8'hA5;
        cs  = hdr ^ seq;
        exp_q.push_back(hdr);
        exp_q.push_back(seq);
`ifdef BAND_READOUT_TIMESTAMP_EN
        if (hit) begin
            exp_q.push_back(8'h12);
            exp_q.push_back(8'h34);
            exp_q.push_back(8'h56);
            cs = cs ^ 8'h12 ^ 8'h34 ^ 8'h56;
        end
`endif
        for (int ch = 0; ch < 2; ch++) begin
            w = d[24*ch +: 24];
            exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
            cs = cs ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        exp_q.push_back(cs);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            cyc();
            n++;
        end
        total++;
        if (n >= 2000) begin
            bad++;
            $display("FAIL %s: drain timeout, %0d bytes still expected", name, exp_q.size());
        end
    endtask

    // Monitor: compare accepted bytes and check that stalled bytes are held.
    always @(negedge clk) begin
        if (!reset_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                total++;
                if (!out_valid || out_data !== held_d) begin
                    bad++;
                    $display("FAIL hold: valid=%0b data=%02h expected valid=1 data=%02h",
                             out_valid, out_data, held_d);
                end
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL byte: got %02h expected no byte", out_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (out_data !== exp_b) begin
                        bad++;
                        $display("FAIL byte: got %02h expected %02h", out_data, exp_b);
                    end
                end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
        end
    end

    initial begin
        int n;
        int base;
        reset_n         = 1'b0;
        rate_bus        = '0;
        tick            = 1'b0;
        bp_bus          = '0;
        trigger_shifter = 4'h0;
        count_1M        = 24'h123456;
        out_ready       = 1'b1;
        cyc();
        cyc();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_drop_rate", {24'd0, drop_rate}, 32'd0);
        chk("rst_drop_hit", {24'd0, drop_hit}, 32'd0);
        reset_n = 1'b1;
        cyc();

        // Rate frame: latency, exact bytes, gapless valid.
        rate_bus = {24'h000102, 24'h0A0B0C};
        exp_q.push_back(8'hA5); exp_q.push_back(8'h00);
        exp_q.push_back(8'h0A); exp_q.push_back(8'h0B); exp_q.push_back(8'h0C);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        exp_q.push_back(8'hAB);
        tick = 1'b1;
        cyc();
        chk("lat_e0", {31'd0, out_valid}, 32'd0);
        cyc();
        chk("lat_e1", {31'd0, out_valid}, 32'd0);
        chk("busy_hdr", {31'd0, busy}, 32'd1);
        cyc();
        chk("lat_e2", {31'd0, out_valid}, 32'd1);
        n = 1;
        while (out_valid && n < 20) begin
            cyc();
            if (out_valid) n++;
        end
        chk("valid_run", n, 32'd9);
        tick = 1'b0;
        cyc();
        push_frame(1'b0, 8'h01, {24'h000102, 24'h0A0B0C});
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        drain("rate_seq1");

        // Hit and rate in the same cycle: hit first, buses changed after capture.
        trigger_shifter = 4'h3;
        bp_bus = 48'hFFFFFF_000001;
        cyc();
        push_frame(1'b1, 8'h00, 48'hFFFFFF_000001);
        push_frame(1'b0, 8'h02, {24'h000102, 24'h0A0B0C});
        base = hs_cnt;
        tick = 1'b1;
        trigger_shifter = 4'h4;
        cyc();
        rate_bus = 48'hDEADBE_EFDEAD;
        bp_bus   = 48'h777777_888888;
        count_1M = 24'hABCDEF;
        tick = 1'b0;
        cyc();
        trigger_shifter = 4'h5;
        drain("hit_rate");
`ifdef BAND_READOUT_TIMESTAMP_EN
        chk("hit_rate_len", hs_cnt - base, 32'd21);
`else
        chk("hit_rate_len", hs_cnt - base, 32'd18);
`endif
        chk("drop_rate_0", {24'd0, drop_rate}, 32'd0);
        chk("drop_hit_0", {24'd0, drop_hit}, 32'd0);
        trigger_shifter = 4'h0;
        count_1M = 24'h123456;

        // Drops while the rate frame is stalled, then saturation.
        rate_bus = 48'h123456_789ABC;
        push_frame(1'b0, 8'h03, 48'h123456_789ABC);
        out_ready = 1'b0;
        tick = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            tick = 1'b0;
            cyc();
            tick = 1'b1;
            cyc();
        end
        chk("drop_rate_3", {24'd0, drop_rate}, 32'd3);
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_hdr", {24'd0, out_data}, 32'hA5);
        for (int i = 0; i < 256; i++) begin
            tick = 1'b0;
            cyc();
            tick = 1'b1;
            cyc();
        end
        chk("drop_rate_sat", {24'd0, drop_rate}, 32'd255);
        tick = 1'b0;
        out_ready = 1'b1;
        drain("stalled_frame");

        // out_ready toggling every cycle.
        rate_bus = 48'hC0FFEE_BADA55;
        push_frame(1'b0, 8'h04, 48'hC0FFEE_BADA55);
        base = hs_cnt;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            out_ready = ~out_ready;
            cyc();
            n++;
        end
        chk("toggle_timeout", (n < 200) ? 32'd1 : 32'd0, 32'd1);
        chk("toggle_len", hs_cnt - base, 32'd9);
        out_ready = 1'b1;
        cyc();

        // Reset while the third data byte is on the bus.
        rate_bus = 48'h111111_222222;
        push_frame(1'b0, 8'h05, 48'h111111_222222);
        base = hs_cnt;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        n = 0;
        while ((hs_cnt - base) < 4 && n < 50) begin
            cyc();
            n++;
        end
        chk("abort_reach", hs_cnt - base, 32'd4);
        exp_q.delete();
        reset_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_drop_rate", {24'd0, drop_rate}, 32'd0);
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
        rate_bus = 48'hABCDEF_012345;
        push_frame(1'b0, 8'h00, 48'hABCDEF_012345);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        drain("post_reset");
        chk("post_drop_rate", {24'd0, drop_rate}, 32'd0);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
